// File: rtl/button_count_pulser.sv
// Turns raw, bouncy up/down push-button levels into clean one-cycle count commands.
// Optional auto-repeat while a button is held: define AUTO_REPEAT_EN.
module button_count_pulser #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000,
  parameter int CNT_W           = 27
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn_up,
  input  logic i_btn_dwn,
  output logic o_cnt_up,
  output logic o_cnt_dwn,
  output logic o_busy
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_PRESS   = 3'd1;
  localparam logic [2:0] ST_HELD    = 3'd2;
  localparam logic [2:0] ST_RELEASE = 3'd4;
`ifdef AUTO_REPEAT_EN
  localparam logic [2:0] ST_REPEAT  = 3'd3;
`endif

  localparam logic DIR_UP  = 1'b0;
  localparam logic DIR_DWN = 1'b1;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] DEB_LIM  = CNT_W'(DEBOUNCE_CYCLES);
`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] DLY_LIM  = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] PER_LIM  = CNT_W'(REPEAT_PERIOD);
`endif

  // Increment that stops at the limit so the timer never wraps.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                               input logic [CNT_W-1:0] lim);
    logic [CNT_W-1:0] nxt;
    if (cnt < lim) begin
      nxt = cnt + CNT_ONE;
    end else begin
      nxt = cnt;
    end
    return nxt;
  endfunction

  logic [1:0]       sync1_q, sync1_d;
  logic [1:0]       sync2_q, sync2_d;
  logic [2:0]       state_q, state_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             cnt_up_q, cnt_up_d;
  logic             cnt_dwn_q, cnt_dwn_d;
  logic             busy_q, busy_d;
`ifdef AUTO_REPEAT_EN
  logic             ret_rep_q, ret_rep_d;
`endif

  logic s_up, s_dwn, sel_s, opp_s, pulse_s;

  assign s_up  = sync2_q[0];
  assign s_dwn = sync2_q[1];
  assign sel_s = (dir_q == DIR_DWN) ? s_dwn : s_up;
  assign opp_s = (dir_q == DIR_DWN) ? s_up : s_dwn;

  // Two-stage synchroniser next state (bit 0 = up, bit 1 = down).
  always_comb begin
    sync1_d = {i_btn_dwn, i_btn_up};
    sync2_d = sync1_q;
  end

  // Debounce / repeat FSM next state.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    timer_d = timer_q;
    pulse_s = 1'b0;
`ifdef AUTO_REPEAT_EN
    ret_rep_d = ret_rep_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (s_up ^ s_dwn) begin
          state_d = ST_PRESS;
          dir_d   = s_dwn ? DIR_DWN : DIR_UP;
          timer_d = CNT_ONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PRESS: begin
        if (!sel_s) begin
          state_d = ST_IDLE;
          timer_d = CNT_ZERO;
        end else if (timer_q == DEB_LIM) begin
          state_d = ST_HELD;
          pulse_s = 1'b1;
          timer_d = CNT_ONE;
        end else begin
          timer_d = sat_inc(timer_q, DEB_LIM);
        end
      end
      ST_HELD: begin
        if (!sel_s) begin
          state_d = ST_RELEASE;
          timer_d = CNT_ONE;
`ifdef AUTO_REPEAT_EN
          ret_rep_d = 1'b0;
        end else if (opp_s) begin
          timer_d = timer_q;
        end else if (timer_q == DLY_LIM) begin
          state_d = ST_REPEAT;
          pulse_s = 1'b1;
          timer_d = CNT_ONE;
        end else begin
          timer_d = sat_inc(timer_q, DLY_LIM);
        end
`else
        end else begin
          timer_d = timer_q;
        end
`endif
      end
`ifdef AUTO_REPEAT_EN
      ST_REPEAT: begin
        if (!sel_s) begin
          state_d   = ST_RELEASE;
          timer_d   = CNT_ONE;
          ret_rep_d = 1'b1;
        end else if (opp_s) begin
          timer_d = timer_q;
        end else if (timer_q == PER_LIM) begin
          pulse_s = 1'b1;
          timer_d = CNT_ONE;
        end else begin
          timer_d = sat_inc(timer_q, PER_LIM);
        end
      end
`endif
      ST_RELEASE: begin
        // A bounce back high restarts the interval of the state we came from.
        if (sel_s) begin
`ifdef AUTO_REPEAT_EN
          state_d = ret_rep_q ? ST_REPEAT : ST_HELD;
`else
          state_d = ST_HELD;
`endif
          timer_d = CNT_ONE;
        end else if (timer_q == DEB_LIM) begin
          state_d = ST_IDLE;
          timer_d = CNT_ZERO;
        end else begin
          timer_d = sat_inc(timer_q, DEB_LIM);
        end
      end
      default: begin
        state_d = ST_IDLE;
        dir_d   = DIR_UP;
        timer_d = CNT_ZERO;
      end
    endcase
  end

  // Registered outputs: pulses steered by the latched direction.
  always_comb begin
    cnt_up_d  = pulse_s && (dir_q == DIR_UP);
    cnt_dwn_d = pulse_s && (dir_q == DIR_DWN);
    busy_d    = (state_d != ST_IDLE);
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync1_q   <= 2'b00;
      sync2_q   <= 2'b00;
      state_q   <= ST_IDLE;
      dir_q     <= DIR_UP;
      timer_q   <= CNT_ZERO;
      cnt_up_q  <= 1'b0;
      cnt_dwn_q <= 1'b0;
      busy_q    <= 1'b0;
`ifdef AUTO_REPEAT_EN
      ret_rep_q <= 1'b0;
`endif
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      state_q   <= state_d;
      dir_q     <= dir_d;
      timer_q   <= timer_d;
      cnt_up_q  <= cnt_up_d;
      cnt_dwn_q <= cnt_dwn_d;
      busy_q    <= busy_d;
`ifdef AUTO_REPEAT_EN
      ret_rep_q <= ret_rep_d;
`endif
    end
  end

  assign o_cnt_up  = cnt_up_q;
  assign o_cnt_dwn = cnt_dwn_q;
  assign o_busy    = busy_q;

endmodule

// File: tb/tb_button_count_pulser.sv
// Scoreboard bench for button_count_pulser: a behavioural model predicts the
// per-cycle outputs, a monitor compares them against the DUT.
module tb_button_count_pulser;

  localparam int DEB = 4;
  localparam int DLY = 10;
  localparam int PER = 5;
`ifdef AUTO_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, up, dwn;
  logic o_up, o_dwn, o_busy;

  always #5 clk = ~clk;

  button_count_pulser #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY(DLY),
    .REPEAT_PERIOD(PER),
    .CNT_W(8)
  ) dut (
    .i_clk(clk),
    .i_reset(rst),
    .i_btn_up(up),
    .i_btn_dwn(dwn),
    .o_cnt_up(o_up),
    .o_cnt_dwn(o_dwn),
    .o_busy(o_busy)
  );

  logic [2:0] exp_q[$];
  logic [2:0] mon_e;
  int n_tests = 0;
  int n_fail  = 0;
  int up_pulses = 0;
  int exp_pulses;

  // Reference model: raw samples pass a two-deep delay, then a press is
  // tracked as idle / debouncing-in / holding / debouncing-out.
  bit p1u, p1d, su, sd;
  int mode;     // 0 idle, 1 press debounce, 2 holding, 3 release debounce
  bit mdir;     // 0 up, 1 down
  int mcnt;
  bit in_period; // holding interval is the repeat period rather than the first delay

  function automatic void mdl_step(input bit r, input bit u, input bit d, output logic [2:0] e);
    bit sel, opp, pulse;
    int lim;
    pulse = 1'b0;
    if (r) begin
      p1u = 0; p1d = 0; su = 0; sd = 0;
      mode = 0; mdir = 0; mcnt = 0; in_period = 0;
    end else begin
      sel = mdir ? sd : su;
      opp = mdir ? su : sd;
      lim = in_period ? PER : DLY;
      if (mode == 0) begin
        if (su != sd) begin mode = 1; mdir = sd; mcnt = 1; end
      end else if (mode == 1) begin
        if (!sel) mode = 0;
        else if (mcnt >= DEB) begin pulse = 1; mode = 2; in_period = 0; mcnt = 1; end
        else mcnt++;
      end else if (mode == 2) begin
        if (!sel) begin mode = 3; mcnt = 1; end
        else if (REP_EN && !opp) begin
          if (mcnt >= lim) begin pulse = 1; in_period = 1; mcnt = 1; end
          else mcnt++;
        end
      end else begin
        if (sel) begin mode = 2; mcnt = 1; end
        else if (mcnt >= DEB) mode = 0;
        else mcnt++;
      end
      su = p1u; sd = p1d; p1u = u; p1d = d;
    end
    e = {pulse && !mdir, pulse && mdir, mode != 0};
  endfunction

  task automatic drive(input bit r, input bit u, input bit d, input int n);
    logic [2:0] e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = r; up = u; dwn = d;
      mdl_step(r, u, d, e);
      exp_q.push_back(e);
    end
  endtask

  // Monitor: one expectation per clock edge, compared just after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        n_tests++;
        if ({o_up, o_dwn, o_busy} !== mon_e) begin
          n_fail++;
          $display("FAIL outputs t=%0t up/dwn/busy got=%b%b%b required=%b",
                   $time, o_up, o_dwn, o_busy, mon_e);
        end
        if (o_up === 1'b1) up_pulses++;
      end
    end
  end

  initial begin
    bit which, main_b, opp_b, r_b;
    int len, gap;
    rst = 1'b1; up = 1'b0; dwn = 1'b0;
    drive(1, 0, 0, 2);

    // Clean press then release.
    drive(0, 1, 0, 8);
    drive(0, 0, 0, 12);

    // Bouncing down button, then held.
    for (int i = 0; i < 20; i++) drive(0, (i % 2) == 0, 0, 1);
    for (int i = 0; i < 20; i++) drive(0, 0, (i % 2) == 0, 1);
    drive(0, 0, 1, 12);
    drive(0, 0, 0, 12);

    // Long hold: auto-repeat count checked independently of the model.
    @(negedge clk);
    up_pulses = 0;
    drive(0, 1, 0, 40);
    drive(0, 0, 0, 12);
    @(posedge clk);
    #2;
    exp_pulses = REP_EN ? 7 : 1;
    n_tests++;
    if (up_pulses != exp_pulses) begin
      n_fail++;
      $display("FAIL repeat_count got=%0d required=%0d", up_pulses, exp_pulses);
    end

    // Simultaneous press.
    drive(0, 1, 1, 20);
    drive(0, 0, 0, 6);

    // Reset while held.
    drive(0, 1, 0, 10);
    drive(1, 1, 0, 1);
    drive(0, 1, 0, 20);
    drive(0, 0, 0, 12);

    // Randomized presses with bounce, opposite-button noise and rare resets.
    for (int ep = 0; ep < 40; ep++) begin
      which = ($urandom_range(0, 1) == 1);
      len = $urandom_range(1, 45);
      for (int c = 0; c < len; c++) begin
        main_b = (c < 3) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) != 0);
        opp_b  = ($urandom_range(0, 7) == 0);
        r_b    = ($urandom_range(0, 99) == 0);
        drive(r_b, which ? opp_b : main_b, which ? main_b : opp_b, 1);
      end
      gap = $urandom_range(0, 14);
      for (int g = 0; g < gap; g++)
        drive(0, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, 1);
    end

    drive(0, 0, 0, 15);
    @(posedge clk);
    #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d required=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
